// File: rtl/led_key_speed_ctrl.sv
// led_key_speed_ctrl: debounces a push key, cycles four step rates per press, emits step_tick.
// Optional long-press pause is built when LED_KEY_LONG_PRESS_EN is defined.
module led_key_speed_ctrl #(
    parameter int unsigned DEBOUNCE_CYC = 1_000_000,
    parameter int unsigned BASE_CYC     = 25_000_000,
    parameter int unsigned LONG_CYC     = 50_000_000
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       key,
    output logic [1:0] speed_idx,
    output logic       step_tick,
    output logic       key_press
);

    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYC);
    localparam int unsigned TICK_W = $clog2(BASE_CYC);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 32'd1);

    if (DEBOUNCE_CYC < 2 || BASE_CYC < 8 || LONG_CYC < 2) begin : g_param_check
        $error("led_key_speed_ctrl: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } db_state_t;

    logic              key_m;
    logic              key_s;
    db_state_t         state;
    logic [DB_W-1:0]   db_cnt;
    logic              press_accept;
    logic [TICK_W-1:0] tick_cnt;
    logic [TICK_W-1:0] tick_last;

    // Released level is 1, so the synchroniser resets to 1 to avoid a phantom press.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            key_m <= 1'b1;
            key_s <= 1'b1;
        end else begin
            key_m <= key;
            key_s <= key_m;
        end
    end

    always_comb begin
        press_accept = (state == PRESS_WAIT) && !key_s && (db_cnt == DB_LAST);
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state     <= IDLE;
            db_cnt    <= '0;
            key_press <= 1'b0;
            speed_idx <= '0;
        end else begin
            key_press <= 1'b0;
            case (state)
                IDLE: begin
                    if (!key_s) begin
                        state  <= PRESS_WAIT;
                        db_cnt <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (key_s) begin
                        state  <= IDLE;
                        db_cnt <= '0;
                    end else if (db_cnt == DB_LAST) begin
                        state     <= PRESSED;
                        db_cnt    <= '0;
                        key_press <= 1'b1;
                        speed_idx <= speed_idx + 2'd1;
                    end else begin
                        db_cnt <= db_cnt + DB_W'(1);
                    end
                end
                PRESSED: begin
                    if (key_s) begin
                        state  <= RELEASE_WAIT;
                        db_cnt <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (!key_s) begin
                        state  <= PRESSED;
                        db_cnt <= '0;
                    end else if (db_cnt == DB_LAST) begin
                        state  <= IDLE;
                        db_cnt <= '0;
                    end else begin
                        db_cnt <= db_cnt + DB_W'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    db_cnt <= '0;
                end
            endcase
        end
    end

`ifdef LED_KEY_LONG_PRESS_EN
    localparam int unsigned HOLD_W = $clog2(LONG_CYC);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 32'd1);

    logic [HOLD_W-1:0] hold_cnt;
    logic              long_done;
    logic              paused;

    // Hold time accumulates only in PRESSED; long_done limits the toggle to once per press.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            hold_cnt  <= '0;
            long_done <= 1'b0;
            paused    <= 1'b0;
        end else if (state == IDLE || state == PRESS_WAIT) begin
            hold_cnt  <= '0;
            long_done <= 1'b0;
        end else if (state == PRESSED && !long_done) begin
            if (hold_cnt == HOLD_LAST) begin
                paused    <= !paused;
                long_done <= 1'b1;
            end else begin
                hold_cnt <= hold_cnt + HOLD_W'(1);
            end
        end
    end
`endif

    always_comb begin
        tick_last = TICK_W'((BASE_CYC >> speed_idx) - 32'd1);
    end

    // A speed change restarts the period and suppresses a coincident tick.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            tick_cnt  <= '0;
            step_tick <= 1'b0;
        end else if (press_accept) begin
            tick_cnt  <= '0;
            step_tick <= 1'b0;
`ifdef LED_KEY_LONG_PRESS_EN
        end else if (paused) begin
            step_tick <= 1'b0;
`endif
        end else if (tick_cnt == tick_last) begin
            tick_cnt  <= '0;
            step_tick <= 1'b1;
        end else begin
            tick_cnt  <= tick_cnt + TICK_W'(1);
            step_tick <= 1'b0;
        end
    end

endmodule

// File: tb/tb_led_key_speed_ctrl.sv
// Self-checking bench for led_key_speed_ctrl: run-length key model plus period arithmetic,
// compared every cycle, with literal checks on latency, periods and the coincidence case.
module tb_led_key_speed_ctrl;

    localparam int unsigned D = 4;
    localparam int unsigned B = 16;
    localparam int unsigned L = 32;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       key     = 1'b1;
    logic [1:0] speed_idx;
    logic       step_tick;
    logic       key_press;

    led_key_speed_ctrl #(
        .DEBOUNCE_CYC(D),
        .BASE_CYC    (B),
        .LONG_CYC    (L)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .key      (key),
        .speed_idx(speed_idx),
        .step_tick(step_tick),
        .key_press(key_press)
    );

    always #5 sys_clk = ~sys_clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned cyc      = 0;
    bit          cmp_en   = 1'b1;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    endtask

    // Reference: a press is accepted after D+1 consecutive low raw samples (D+1 high to
    // release), seen at the outputs two edges later through the synchroniser.
    int unsigned m_speed, m_since, low_run, high_run;
    bit          m_level_pressed, pend0, pend1, m_press, m_tick;

    always @(posedge sys_clk) begin
        cyc++;
        if (sys_rst) begin
            m_speed = 0; m_since = 0; low_run = 0; high_run = 0;
            m_level_pressed = 0; pend0 = 0; pend1 = 0; m_press = 0; m_tick = 0;
        end else begin
            m_press = pend1;
            pend1   = pend0;
            pend0   = 0;
            if (!m_level_pressed) begin
                if (!key) begin
                    low_run++;
                    if (low_run == D + 1) begin
                        pend0 = 1; m_level_pressed = 1; low_run = 0;
                    end
                end else low_run = 0;
            end else begin
                if (key) begin
                    high_run++;
                    if (high_run == D + 1) begin
                        m_level_pressed = 0; high_run = 0;
                    end
                end else high_run = 0;
            end
            m_tick = 0;
            if (m_press) begin
                m_speed = (m_speed + 1) % 4;
                m_since = 0;
            end else begin
                m_since++;
                if (m_since == (B >> m_speed)) begin
                    m_tick  = 1;
                    m_since = 0;
                end
            end
        end
    end

    always @(negedge sys_clk) begin
        if (cmp_en) begin
            check("model_speed_idx", speed_idx, m_speed);
            check("model_key_press", key_press, m_press);
            check("model_step_tick", step_tick, m_tick);
        end
    end

    task automatic wait_tick(input int unsigned limit, output int unsigned n);
        n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (!step_tick && n < limit);
        if (!step_tick) n = 0;
    endtask

    task automatic press(input int unsigned low_n, input int unsigned high_n,
                         output int unsigned presses);
        presses = 0;
        key = 1'b0;
        repeat (low_n) begin
            @(negedge sys_clk);
            if (key_press) presses++;
        end
        key = 1'b1;
        repeat (high_n) begin
            @(negedge sys_clk);
            if (key_press) presses++;
        end
    endtask

    task automatic do_reset(input int unsigned n);
        sys_rst = 1'b1;
        repeat (n) @(negedge sys_clk);
        sys_rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned n, presses, n_at, t_at, pc, ticks;
        int unsigned exp_speed [4] = '{1, 2, 3, 0};
        int unsigned exp_per   [4] = '{8, 4, 2, 16};

        // 1: reset state and base period
        repeat (10) @(negedge sys_clk);
        check("rst_speed_idx", speed_idx, 0);
        check("rst_key_press", key_press, 0);
        check("rst_step_tick", step_tick, 0);
        sys_rst = 1'b0;
        wait_tick(40, n);
        check("first_tick_delay", n, 16);
        wait_tick(40, n);
        check("period_speed0", n, 16);

        // 2: bouncing press, exact latency
        key = 1'b0; @(negedge sys_clk);
        key = 1'b1; repeat (2) @(negedge sys_clk);
        key = 1'b0; @(negedge sys_clk);
        key = 1'b1; @(negedge sys_clk);
        key = 1'b0; repeat (2) @(negedge sys_clk);
        key = 1'b1; @(negedge sys_clk);
        key = 1'b0;
        n_at = cyc + 1;
        presses = 0; pc = 0;
        repeat (10) begin
            @(negedge sys_clk);
            if (key_press) begin presses++; pc = cyc; end
        end
        check("bounce_press_count", presses, 1);
        check("press_latency", pc - n_at, D + 2);
        check("bounce_speed_idx", speed_idx, 1);
        key = 1'b1;
        wait_tick(40, n);
        wait_tick(40, n);
        check("period_speed1", n, 8);

        // 3: four clean presses from speed 0
        do_reset(2);
        repeat (4) @(negedge sys_clk);
        for (int i = 0; i < 4; i++) begin
            press(8, 8, presses);
            check("clean_press_count", presses, 1);
            check("clean_speed_idx", speed_idx, exp_speed[i]);
            wait_tick(40, n);
            wait_tick(40, n);
            check("clean_period", n, exp_per[i]);
        end

        // 4: debounce point lands on the terminal count (speed 0, period 16)
        wait_tick(40, n);
        t_at = cyc;
        repeat (9) @(negedge sys_clk);
        key = 1'b0;
        repeat (7) @(negedge sys_clk);
        check("coincide_cycle", cyc - t_at, 16);
        check("coincide_key_press", key_press, 1);
        check("coincide_no_tick", step_tick, 0);
        check("coincide_speed_idx", speed_idx, 1);
        wait_tick(40, n);
        check("coincide_next_period", n, 8);
        key = 1'b1;
        repeat (10) @(negedge sys_clk);

        // 5: reset while key is low at speed 2
        press(8, 8, presses);
        check("pre_reset_speed_idx", speed_idx, 2);
        key = 1'b0;
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        t_at = cyc;
        sys_rst = 1'b0;
        check("midrst_speed_idx", speed_idx, 0);
        check("midrst_key_press", key_press, 0);
        check("midrst_step_tick", step_tick, 0);
        presses = 0; pc = 0;
        repeat (8) begin
            @(negedge sys_clk);
            if (key_press) begin presses++; pc = cyc; end
        end
        check("post_rst_press_count", presses, 1);
        check("post_rst_press_cycle", pc - t_at, D + 3);
        check("post_rst_speed_idx", speed_idx, 1);
        key = 1'b1;
        repeat (12) @(negedge sys_clk);

`ifndef LED_KEY_LONG_PRESS_EN
        // randomized key activity with occasional resets, checked by the model every cycle
        for (int s = 0; s < 300; s++) begin
            if ($urandom_range(0, 99) < 3) begin
                sys_rst = 1'b1;
                @(negedge sys_clk);
                sys_rst = 1'b0;
            end
            key = ~key;
            if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 4)) @(negedge sys_clk);
            else repeat ($urandom_range(5, 15)) @(negedge sys_clk);
        end
        key = 1'b1;
        repeat (12) @(negedge sys_clk);
`else
        // 6: long presses toggle the pause
        cmp_en = 1'b0;
        do_reset(2);
        repeat (4) @(negedge sys_clk);
        press(40, 12, presses);
        check("long1_press_count", presses, 1);
        check("long1_speed_idx", speed_idx, 1);
        ticks = 0;
        repeat (40) begin
            @(negedge sys_clk);
            if (step_tick) ticks++;
        end
        check("paused_tick_count", ticks, 0);
        press(40, 12, presses);
        check("long2_press_count", presses, 1);
        check("long2_speed_idx", speed_idx, 2);
        ticks = 0;
        repeat (40) begin
            @(negedge sys_clk);
            if (step_tick) ticks++;
        end
        check("resumed_tick_count", ticks, 10);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/led_key_speed_ctrl.md
Name: led_key_speed_ctrl

Overview:
Upstream control stage for the flow LED block. It debounces one push key and cycles through four flow speeds on each clean press. It emits a one-cycle step_tick at the selected rate, which the flow LED stage uses to advance its pattern by one step.

Parameters:
DEBOUNCE_CYC, 1_000_000, consecutive stable cycles of the synchronised key required to accept a level change (20 ms at 50 MHz); must be >= 2
BASE_CYC, 25_000_000, step period in cycles at speed_idx 0; must be >= 8
LONG_CYC, 50_000_000, hold time in cycles that counts as a long press; used only with the optional feature

Ports:
sys_clk  input  1  system clock, 50 MHz
sys_rst  input  1  synchronous reset, active-high
key  input  1  raw push key, active-low, asynchronous to sys_clk, bouncing
speed_idx  output  2  current speed index; step period = BASE_CYC >> speed_idx
step_tick  output  1  one-cycle pulse, once per step period
key_press  output  1  one-cycle pulse on each accepted press

Behaviour:
- Reset values, applied on any edge where sys_rst=1:
  - outputs: speed_idx=0, step_tick=0, key_press=0
  - synchroniser flops=1 (released), debounce FSM=IDLE, all counters=0
- Synchroniser: 2-flop on key, giving key_s.
- Debounce FSM, single counter db_cnt, width clog2(DEBOUNCE_CYC):
  - IDLE (stable released): key_s=0 -> PRESS_WAIT with db_cnt=0.
  - PRESS_WAIT:
    - key_s=1 -> back to IDLE, db_cnt=0.
    - Otherwise db_cnt++.
    - At db_cnt==DEBOUNCE_CYC-1 with key_s=0 -> PRESSED, and key_press=1 for exactly one cycle.
  - PRESSED: key_s=1 -> RELEASE_WAIT with db_cnt=0.
  - RELEASE_WAIT:
    - key_s=0 -> back to PRESSED.
    - At db_cnt==DEBOUNCE_CYC-1 with key_s=1 -> IDLE. No pulse on release.
- Latency: let edge N be the first edge that samples key=0, with key held low afterwards. key_press is high in the cycle following edge N+2+DEBOUNCE_CYC.
- speed_idx: increments by 1 in the same edge that sets key_press; wraps 3 -> 0.
- Tick counter, width clog2(BASE_CYC):
  - Counts 0 .. (BASE_CYC>>speed_idx)-1.
  - step_tick=1 in the cycle after the counter holds its terminal value; counter returns to 0.
  - Steady-state ticks are exactly BASE_CYC>>speed_idx cycles apart.
- Simultaneous speed change and terminal count: the speed change wins. No tick is issued, the counter clears to 0, and the next tick comes one full new period later.
- Any bounce shorter than DEBOUNCE_CYC produces no key_press and no speed change.
- Reset mid-operation: all state returns to reset values on the next edge. A key still held low across reset release is treated as a new press and must be fully debounced again.
- First tick after reset: BASE_CYC cycles after reset deasserts.

Optional Feature:
Macro: LED_KEY_LONG_PRESS_EN
- Defined:
  - An added hold counter runs while the FSM is PRESSED.
  - On reaching LONG_CYC it toggles an internal pause flag, at most once per press.
  - While paused, step_tick is forced to 0 and the tick counter holds its value; it resumes from that value when unpaused.
  - A press that becomes a long press still produces key_press and the speed increment at its debounce point.
  - Reset clears pause.
- Not defined: no hold counter, no pause flag; step_tick is never suppressed.

Test Plan:
Bench parameters: DEBOUNCE_CYC=4, BASE_CYC=16, LONG_CYC=32.
1. Reset held 10 cycles, key=1 -> speed_idx=0, key_press=0; first step_tick 16 cycles after reset release, then every 16 cycles.
2. key low with 3 toggles of 1-2 cycles each, then held low 10 cycles -> exactly one key_press, at the edge defined under Latency; speed_idx=1; ticks now 8 cycles apart.
3. Four clean presses (low 8 cycles, high 8 cycles each) -> speed_idx sequence 1,2,3,0; periods 8,4,2,16; each press gives one key_press and no pulse on release.
4. Press timed so the debounce point coincides with the tick counter's terminal value -> no step_tick that cycle; next tick one new period later.
5. sys_rst asserted for 1 cycle at speed_idx=2 with key held low -> outputs return to reset values; key held 6 more cycles gives a fresh key_press and speed_idx=1.
6. With LED_KEY_LONG_PRESS_EN defined: hold key low 40 cycles -> one key_press, speed_idx+1, then step_tick stops. A second 40-cycle hold -> speed_idx+1 and ticks resume.
